// File: rtl/pl_hazard_ctrl.sv
// Pipeline control shift chain with load-use stall, forwarding selects,
// flush bubble insertion and a saturating stall counter.
module pl_hazard_ctrl #(
    parameter  int CTRL_W     = 8,
    parameter  int DEPTH      = 3,
    parameter  int LOAD_STAGE = 2,
    parameter  int CNT_W      = 16,
    localparam int FW         = $clog2(DEPTH + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      id_valid,
    input  logic [CTRL_W-1:0]         id_ctrl,
    input  logic [4:0]                id_rd,
    input  logic [4:0]                id_rs1,
    input  logic [4:0]                id_rs2,
    input  logic                      id_use_rs1,
    input  logic                      id_use_rs2,
    input  logic                      id_regwen,
    input  logic                      id_is_load,
    input  logic                      flush,
    output logic                      stall_if,
    output logic [FW-1:0]             fwd_a_sel,
    output logic [FW-1:0]             fwd_b_sel,
    output logic [DEPTH-1:0]          stg_valid,
    output logic [DEPTH*CTRL_W-1:0]   stg_ctrl,
    output logic [4:0]                wb_rd,
    output logic                      wb_regwen,
    output logic [CNT_W-1:0]          stall_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // index i holds stage i+1 (EX at 0, WB at DEPTH-1)
    logic [DEPTH-1:0]             vld_q;
    logic [DEPTH-1:0][CTRL_W-1:0] ctrl_q;
    logic [DEPTH-1:0][4:0]        rd_q;
    logic [DEPTH-1:0]             wen_q;
    logic [DEPTH-1:0]             ld_q;
    logic [CNT_W-1:0]             cnt_q;

    logic                         s1_vld_d;
    logic [CTRL_W-1:0]            s1_ctrl_d;
    logic [4:0]                   s1_rd_d;
    logic                         s1_wen_d;
    logic                         s1_ld_d;
    logic [CNT_W-1:0]             cnt_d;

    logic [DEPTH-1:0]             hit_a;
    logic [DEPTH-1:0]             hit_b;
    logic [FW-1:0]                sel_a;
    logic [FW-1:0]                sel_b;
    logic                         ld_a;
    logic                         ld_b;
    logic                         use_stall_a;
    logic                         use_stall_b;

    // per-stage writer match against each decode source
    always_comb begin
        hit_a = '0;
        hit_b = '0;
        for (int i = 0; i < DEPTH; i++) begin
            hit_a[i] = vld_q[i] & wen_q[i] & (rd_q[i] != 5'd0)
                     & (rd_q[i] == id_rs1) & id_use_rs1;
            hit_b[i] = vld_q[i] & wen_q[i] & (rd_q[i] != 5'd0)
                     & (rd_q[i] == id_rs2) & id_use_rs2;
        end
    end

    // youngest matching stage wins: scan oldest to youngest, last hit sticks
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        ld_a  = 1'b0;
        ld_b  = 1'b0;
        for (int k = DEPTH; k >= 1; k--) begin
            if (hit_a[k-1]) begin
                sel_a = FW'(k);
                ld_a  = ld_q[k-1];
            end
            if (hit_b[k-1]) begin
                sel_b = FW'(k);
                ld_b  = ld_q[k-1];
            end
        end
    end

    assign use_stall_a = (|hit_a) & ld_a & (sel_a < FW'(LOAD_STAGE));
    assign use_stall_b = (|hit_b) & ld_b & (sel_b < FW'(LOAD_STAGE));

    assign stall_if  = id_valid & ~flush & (use_stall_a | use_stall_b);
    assign fwd_a_sel = sel_a;
    assign fwd_b_sel = sel_b;

    // stage 1 takes the decode instruction only when it really issues
    always_comb begin
        s1_vld_d  = id_valid & ~flush & ~stall_if;
        s1_ctrl_d = s1_vld_d ? id_ctrl    : '0;
        s1_rd_d   = s1_vld_d ? id_rd      : 5'd0;
        s1_wen_d  = s1_vld_d & id_regwen;
        s1_ld_d   = s1_vld_d & id_is_load;
        cnt_d     = cnt_q;
        if (stall_if && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // free-running shift of the control chain plus stall counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q  <= '0;
            ctrl_q <= '0;
            rd_q   <= '0;
            wen_q  <= '0;
            ld_q   <= '0;
            cnt_q  <= '0;
        end else begin
            vld_q  <= {vld_q[DEPTH-2:0], s1_vld_d};
            ctrl_q <= {ctrl_q[DEPTH-2:0], s1_ctrl_d};
            rd_q   <= {rd_q[DEPTH-2:0], s1_rd_d};
            wen_q  <= {wen_q[DEPTH-2:0], s1_wen_d};
            ld_q   <= {ld_q[DEPTH-2:0], s1_ld_d};
            cnt_q  <= cnt_d;
        end
    end

    assign stg_valid = vld_q;
    assign stg_ctrl  = ctrl_q;
    assign wb_rd     = rd_q[DEPTH-1];
    assign wb_regwen = vld_q[DEPTH-1] & wen_q[DEPTH-1];
    assign stall_cnt = cnt_q;

endmodule
